branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_branch  in  1  branch instruction (beq/bne) present in ID stage.
REQ-005 id_bne  in  1  1 = bne, 0 = beq; meaningful only while id_branch=1.
REQ-006 id_rs, id_rt  in  5 each  branch source register numbers.
REQ-007 ex_regwrite, ex_memread  in  1 each  EX-stage instruction writes a register / is a load.
REQ-008 ex_rd  in  5  EX-stage destination register.
REQ-009 mem_memread  in  1  MEM-stage instruction is a load.
REQ-010 mem_rd  in  5  MEM-stage destination register.
REQ-011 cmp_result  in  1  equality comparator output, already inverted for bne.
REQ-012 cmp_bne  out  1  drives the comparator's bne select.
REQ-013 stall  out  1  holds PC and IF/ID; inserts a bubble into EX.
REQ-014 pc_src  out  1  selects the branch target as next PC.
REQ-015 if_flush  out  1  squashes the instruction in IF/ID.
REQ-016 taken_cnt  out  16  count of taken branches.
REQ-017 stall_cnt  out  16  count of branch stall cycles.

Function
REQ-018 State machine SHALL have states IDLE, STALL and RESOLVE, plus a 2-bit down-counter wait_cnt.
REQ-019 cmp_bne SHALL equal id_bne when id_branch=1, else 0.
REQ-020 Per-operand hazard need SHALL be computed for id_rs and id_rt; register 0 never hazards:
- match ex_rd with ex_memread=1 -> 2
- else match ex_rd with ex_regwrite=1 -> 1
- else match mem_rd with mem_memread=1 -> 1
- else 0.
REQ-021 N SHALL be max(need_rs, need_rt).
REQ-022 IDLE, id_branch=1, N=0: resolve in the same cycle:
- pc_src = cmp_result, if_flush = cmp_result, stall = 0
- remain IDLE.
REQ-023 IDLE, id_branch=1, N>0: stall=1 that cycle, load wait_cnt=N-1, next state STALL if N=2, else RESOLVE.
REQ-024 STALL: stall=1; decrement wait_cnt; next state RESOLVE when wait_cnt=0 at the edge; hazards are not re-evaluated.
REQ-025 RESOLVE: stall=0; pc_src = if_flush = cmp_result; next state IDLE; no hazard evaluation this cycle.
REQ-026 If id_branch=0 in STALL or RESOLVE, the FSM SHALL abort to IDLE with stall=pc_src=if_flush=0 that cycle.
REQ-027 stall, pc_src and if_flush SHALL be combinational from state and inputs; no output SHALL assert when id_branch=0.
REQ-028 taken_cnt SHALL increment by 1 on each resolve cycle with cmp_result=1, saturating at 16'hFFFF.
REQ-029 stall_cnt SHALL increment by 1 on each cycle with stall=1, saturating at 16'hFFFF.

Reset
REQ-030 While rst_n=0, the block SHALL hold: state IDLE, wait_cnt=0, taken_cnt=0, stall_cnt=0.
REQ-031 While rst_n=0, stall, pc_src, if_flush and cmp_bne SHALL all be 0, regardless of inputs.
REQ-032 Reset asserted mid-stall SHALL drop stall immediately, without waiting for a clock edge.
REQ-033 After reset release, the first evaluation SHALL occur in IDLE.

Verification
REQ-034 No hazard: beq, rs=3, rt=4, cmp_result=1 -> same cycle pc_src=1, if_flush=1, stall=0; taken_cnt=1.
REQ-035 ALU hazard: ex_regwrite=1, ex_rd=3, rs=3 -> one stall cycle; RESOLVE next cycle; stall_cnt=1.
REQ-036 Load-use in EX: ex_memread=1, ex_rd=4, rt=4, bne -> stall two cycles (IDLE, STALL); RESOLVE third cycle with cmp_bne=1; stall_cnt=2.
REQ-037 Register 0: ex_regwrite=1, ex_rd=0, rs=0 -> no stall; resolve immediately.
REQ-038 Abort and reset: id_branch drops in STALL -> IDLE, no pc_src; rst_n=0 mid-stall -> stall=0 asynchronously, counters=0.
REQ-039 Saturation: taken_cnt preloaded to 16'hFFFF via 65535 taken branches, then one more taken branch -> taken_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution control: detects operand hazards against EX/MEM,
// stalls until the comparator operands are forwardable, then redirects the PC.
module branch_resolve_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_branch,
    input  logic        id_bne,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic        cmp_result,
    output logic        cmp_bne,
    output logic        stall,
    output logic        pc_src,
    output logic        if_flush,
    output logic [15:0] taken_cnt,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] wait_cnt;
    logic [1:0] wait_dec;
    logic [1:0] need_rs;
    logic [1:0] need_rt;
    logic [1:0] need_max;
    logic       resolve;

    // Stall cycles an operand still needs before its value can reach the comparator.
    function automatic logic [1:0] hazard_need(
        input logic [4:0] src,
        input logic       ex_wr,
        input logic       ex_ld,
        input logic [4:0] ex_dst,
        input logic       mem_ld,
        input logic [4:0] mem_dst
    );
        logic [1:0] need;
        need = 2'd0;
        if (src != 5'd0) begin
            if (ex_ld && (ex_dst == src))
                need = 2'd2;
            else if (ex_wr && (ex_dst == src))
                need = 2'd1;
            else if (mem_ld && (mem_dst == src))
                need = 2'd1;
        end
        return need;
    endfunction

    always_comb begin
        need_rs  = hazard_need(id_rs, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd);
        need_rt  = hazard_need(id_rt, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd);
        need_max = (need_rs > need_rt) ? need_rs : need_rt;
    end

    // Outputs are gated by rst_n so an asserted reset silences them without a clock edge.
    always_comb begin
        stall    = 1'b0;
        pc_src   = 1'b0;
        if_flush = 1'b0;
        resolve  = 1'b0;
        cmp_bne  = rst_n & id_branch & id_bne;
        if (rst_n && id_branch) begin
            case (state)
                IDLE: begin
                    if (need_max == 2'd0) begin
                        resolve  = 1'b1;
                        pc_src   = cmp_result;
                        if_flush = cmp_result;
                    end else begin
                        stall = 1'b1;
                    end
                end
                STALL: begin
                    stall = 1'b1;
                end
                RESOLVE: begin
                    resolve  = 1'b1;
                    pc_src   = cmp_result;
                    if_flush = cmp_result;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    // The counter is decremented on the STALL edge; RESOLVE follows once it lands on zero.
    assign wait_dec = (wait_cnt == 2'd0) ? 2'd0 : (wait_cnt - 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_branch && (need_max != 2'd0)) begin
                        wait_cnt <= need_max - 2'd1;
                        state    <= (need_max == 2'd2) ? STALL : RESOLVE;
                    end
                end
                STALL: begin
                    if (!id_branch) begin
                        state    <= IDLE;
                        wait_cnt <= 2'd0;
                    end else begin
                        wait_cnt <= wait_dec;
                        if (wait_dec == 2'd0)
                            state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    state    <= IDLE;
                    wait_cnt <= 2'd0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (resolve && cmp_result && (taken_cnt != 16'hFFFF))
                taken_cnt <= taken_cnt + 16'd1;
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; inputs change on the falling edge
// and outputs are checked 1ns later, well away from the rising edge.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_branch;
    logic        id_bne;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;
    logic        cmp_result;
    logic        cmp_bne;
    logic        stall;
    logic        pc_src;
    logic        if_flush;
    logic [15:0] taken_cnt;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;

    int vectors;
    int miscompares;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STALL   = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;

    branch_resolve_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_branch   (id_branch),
        .id_bne      (id_bne),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .cmp_result  (cmp_result),
        .cmp_bne     (cmp_bne),
        .stall       (stall),
        .pc_src      (pc_src),
        .if_flush    (if_flush),
        .taken_cnt   (taken_cnt),
        .stall_cnt   (stall_cnt),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_stall, input logic e_pc, input logic e_fl);
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, e_stall});
        chk({tag, ".pc_src"}, {15'd0, pc_src}, {15'd0, e_pc});
        chk({tag, ".if_flush"}, {15'd0, if_flush}, {15'd0, e_fl});
    endtask

    task automatic clear_haz();
        ex_regwrite = 1'b0;
        ex_memread  = 1'b0;
        ex_rd       = 5'd0;
        mem_memread = 1'b0;
        mem_rd      = 5'd0;
    endtask

    task automatic next_step();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        id_branch   = 1'b1;
        id_bne      = 1'b1;
        id_rs       = 5'd3;
        id_rt       = 5'd4;
        ex_regwrite = 1'b1;
        ex_memread  = 1'b1;
        ex_rd       = 5'd3;
        mem_memread = 1'b0;
        mem_rd      = 5'd0;
        cmp_result  = 1'b1;

        // Reset holds everything quiet even with a hazarding branch on the inputs.
        repeat (2) next_step();
        #1;
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.cmp_bne", {15'd0, cmp_bne}, 16'd0);
        chk("rst.taken", taken_cnt, 16'd0);
        chk("rst.stallc", stall_cnt, 16'd0);
        chk("rst.state", {14'd0, state_dbg}, {14'd0, S_IDLE});

        // No hazard, beq taken: resolves in the same cycle.
        next_step();
        rst_n = 1'b1;
        clear_haz();
        id_bne = 1'b0; id_rs = 5'd3; id_rt = 5'd4; cmp_result = 1'b1;
        #1;
        chk_out("nohaz", 1'b0, 1'b1, 1'b1);
        chk("nohaz.cmp_bne", {15'd0, cmp_bne}, 16'd0);
        next_step();
        id_branch = 1'b0;
        #1;
        chk_out("nobr", 1'b0, 1'b0, 1'b0);
        chk("nohaz.taken", taken_cnt, 16'd1);
        chk("nohaz.state", {14'd0, state_dbg}, {14'd0, S_IDLE});

        // ALU hazard on rs: one stall cycle then RESOLVE.
        next_step();
        id_branch = 1'b1; id_rs = 5'd3; ex_regwrite = 1'b1; ex_rd = 5'd3; cmp_result = 1'b0;
        #1;
        chk_out("alu.idle", 1'b1, 1'b0, 1'b0);
        next_step();
        clear_haz();
        cmp_result = 1'b1;
        #1;
        chk("alu.state", {14'd0, state_dbg}, {14'd0, S_RESOLVE});
        chk_out("alu.res", 1'b0, 1'b1, 1'b1);
        next_step();
        id_branch = 1'b0;
        #1;
        chk("alu.stallc", stall_cnt, 16'd1);
        chk("alu.taken", taken_cnt, 16'd2);
        chk("alu.back", {14'd0, state_dbg}, {14'd0, S_IDLE});

        // Load in EX feeding rt of a bne: two stalls (IDLE, STALL), RESOLVE third.
        next_step();
        id_branch = 1'b1; id_bne = 1'b1; id_rs = 5'd7; id_rt = 5'd4;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd4; cmp_result = 1'b0;
        #1;
        chk_out("ld.idle", 1'b1, 1'b0, 1'b0);
        chk("ld.cmp_bne", {15'd0, cmp_bne}, 16'd1);
        next_step();
        clear_haz();
        #1;
        chk("ld.state1", {14'd0, state_dbg}, {14'd0, S_STALL});
        chk_out("ld.stall", 1'b1, 1'b0, 1'b0);
        next_step();
        cmp_result = 1'b1;
        #1;
        chk("ld.state2", {14'd0, state_dbg}, {14'd0, S_RESOLVE});
        chk_out("ld.res", 1'b0, 1'b1, 1'b1);
        chk("ld.res_bne", {15'd0, cmp_bne}, 16'd1);
        next_step();
        id_branch = 1'b0;
        #1;
        chk("ld.stallc", stall_cnt, 16'd3);
        chk("ld.taken", taken_cnt, 16'd3);
        chk("ld.nobr_bne", {15'd0, cmp_bne}, 16'd0);

        // Load in MEM on rs: one stall, resolve not taken.
        next_step();
        id_branch = 1'b1; id_bne = 1'b0; id_rs = 5'd9; id_rt = 5'd1;
        mem_memread = 1'b1; mem_rd = 5'd9; cmp_result = 1'b0;
        #1;
        chk_out("mem.idle", 1'b1, 1'b0, 1'b0);
        next_step();
        clear_haz();
        #1;
        chk("mem.state", {14'd0, state_dbg}, {14'd0, S_RESOLVE});
        chk_out("mem.res", 1'b0, 1'b0, 1'b0);
        next_step();
        id_branch = 1'b0;
        #1;
        chk("mem.stallc", stall_cnt, 16'd4);
        chk("mem.taken", taken_cnt, 16'd3);

        // Register 0 never hazards, even against a load writing r0.
        next_step();
        id_branch = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0; cmp_result = 1'b1;
        #1;
        chk_out("r0", 1'b0, 1'b1, 1'b1);
        next_step();
        id_branch = 1'b0;
        clear_haz();
        #1;
        chk("r0.taken", taken_cnt, 16'd4);
        chk("r0.stallc", stall_cnt, 16'd4);

        // Abort: branch disappears while in STALL.
        next_step();
        id_branch = 1'b1; id_rs = 5'd5; id_rt = 5'd2;
        ex_memread = 1'b1; ex_rd = 5'd5; cmp_result = 1'b1;
        next_step();
        clear_haz();
        #1;
        chk("ab.state", {14'd0, state_dbg}, {14'd0, S_STALL});
        next_step();
        id_branch = 1'b0;
        #1;
        chk_out("ab.drop", 1'b0, 1'b0, 1'b0);
        next_step();
        #1;
        chk("ab.state2", {14'd0, state_dbg}, {14'd0, S_IDLE});
        chk("ab.stallc", stall_cnt, 16'd6);
        chk("ab.taken", taken_cnt, 16'd4);

        // Reset asserted mid-stall drops stall before any clock edge.
        id_branch = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        next_step();
        clear_haz();
        #1;
        chk_out("rs.pre", 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("rs.async", 1'b0, 1'b0, 1'b0);
        chk("rs.taken", taken_cnt, 16'd0);
        chk("rs.stallc", stall_cnt, 16'd0);
        chk("rs.state", {14'd0, state_dbg}, {14'd0, S_IDLE});

        // After release: first evaluation in IDLE, then saturate taken_cnt.
        next_step();
        rst_n = 1'b1; id_rs = 5'd3; id_rt = 5'd4; cmp_result = 1'b1;
        #1;
        chk_out("rel", 1'b0, 1'b1, 1'b1);
        repeat (65535) @(negedge clk);
        #1;
        chk("sat.full", taken_cnt, 16'hFFFF);
        chk("sat.stallc", stall_cnt, 16'd0);
        chk_out("sat.more", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("sat.hold", taken_cnt, 16'hFFFF);

        id_branch = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
